icache_upstream_arb: RTL and testbench
======================================

Name: icache_upstream_arb

Overview:
- Parametrised N-channel front end for the icache upstream port.
- Round-robin arbitrates N requestor channels onto the single upstream rxreq channel and stamps each request with a txnid = {channel id, per-channel sequence}.
- Routes upstream txdat responses, which may arrive out of order, back to the originating channel through a one-entry per-channel response register.
- Enforces a per-channel outstanding-request credit limit, which the single-requestor port lacks.

Parameters:
- NUM_CH, 4, number of requestor channels (power of 2, >=2); CH_W = log2(NUM_CH).
- TXNID_W, 6, upstream txnid width; SEQ_W = TXNID_W - CH_W (must be >=1).
- DATA_W, 256, upstream response data width.
- REQ_W, 64, packed pc_req_t width.
- MAX_OUTST, 4, per-channel outstanding limit (1..2^SEQ_W).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ch_req_vld  in  NUM_CH  per-channel request valid.
- ch_req_rdy  out  NUM_CH  per-channel request ready (one-hot grant).
- ch_req_pld  in  NUM_CH*REQ_W  per-channel request payload, channel i at [i*REQ_W +: REQ_W].
- upstream_rxreq_vld  out  1  registered request valid.
- upstream_rxreq_rdy  in  1  icache ready.
- upstream_rxreq_pld  out  REQ_W  registered payload.
- upstream_rxreq_txnid  out  TXNID_W  {ch, seq}.
- upstream_txdat_vld  in  1  response valid.
- upstream_txdat_rdy  out  1  response ready.
- upstream_txdat_data  in  DATA_W  response data.
- upstream_txdat_txnid  in  TXNID_W  response txnid.
- ch_rsp_vld  out  NUM_CH  per-channel response valid.
- ch_rsp_rdy  in  NUM_CH  per-channel response ready.
- ch_rsp_data  out  NUM_CH*DATA_W  per-channel response data.
- ch_rsp_seq  out  NUM_CH*SEQ_W  sequence number of the delivered response.
- err_bad_rsp  out  1  one-cycle pulse when a response is dropped.
- idle  out  1  no request held, no response buffered, all counts zero.

Behaviour:
- Reset (synchronous, rst=1 at the clk edge):
  - upstream_rxreq_vld=0, ch_rsp_vld=0, err_bad_rsp=0, idle=1.
  - RR pointer=0; all outstanding counts=0; all sequence counters=0.
  - Reset mid-operation discards held requests and buffered responses with no handshake.
- Eligibility: channel i is eligible when ch_req_vld[i] && cnt[i] < MAX_OUTST.
- Request register (REQ_REG) is free when empty, or when it is full and upstream_rxreq_rdy=1 in the same cycle (full throughput, one request per cycle).
- Arbitration:
  - If REQ_REG is free, grant the first eligible channel at or after the RR pointer, searching upward with wrap.
  - ch_req_rdy = grant, purely combinational from vld/cnt/register state; zero when REQ_REG is not free.
  - On grant, the pointer moves to winner+1 mod NUM_CH. With no grant the pointer holds.
- Grant actions (winner i):
  - Load pld into REQ_REG; txnid = {i[CH_W-1:0], seq[i]}.
  - seq[i] increments mod 2^SEQ_W.
  - cnt[i] increments.
- Latency: upstream_rxreq_vld rises the cycle after the ch handshake. vld/pld/txnid stay stable until the upstream handshake.
- Response decode: c = txnid[TXNID_W-1:SEQ_W].
  - Valid case (c < NUM_CH and cnt[c] != 0): upstream_txdat_rdy = !rsp_vld[c] || ch_rsp_rdy[c]. On handshake, load data and seq into RSP_REG[c]; ch_rsp_vld[c] rises next cycle.
  - Bad case (c >= NUM_CH, only possible when the txnid space exceeds NUM_CH, or cnt[c]==0): rdy=1, data dropped, err_bad_rsp pulses next cycle, no state change.
- cnt[c] decrements on the ch_rsp handshake, not on upstream acceptance. Simultaneous increment and decrement on the same channel leaves cnt unchanged. cnt never exceeds MAX_OUTST, and a channel at MAX_OUTST is skipped by the arbiter.
- Responses are delivered per channel in arrival order; no reordering to sequence order. The consumer uses ch_rsp_seq.
- RSP_REG[c] accepts a new response in the same cycle its current one drains.
- idle is a registered function of state only.

Test Plan:
- Single channel: ch0 issues 3 requests with rdy=1 -> txnids 0x00, 0x01, 0x02 on consecutive cycles, 1-cycle latency. Responses returned -> ch_rsp_seq 0, 1, 2; cnt returns to 0; idle=1.
- Contention: all 4 channels hold vld continuously, upstream rdy=1 -> grant order 0,1,2,3,0,1... with exactly one grant per cycle.
- Credit stall: ch2 issues 4 requests (MAX_OUTST=4) with no responses -> ch_req_rdy[2]=0 while ch1 is still granted. One ch2 response delivered -> ch2 is granted again the next eligible cycle.
- Out of order plus backpressure: responses with txnids 0x31, 0x10, 0x30 while ch_rsp_rdy[3]=0 -> 0x31 is buffered; 0x10 reaches ch1; 0x30 sees upstream_txdat_rdy=0 until ch3 drains, then delivers seq 0.
- Upstream backpressure: upstream_rxreq_rdy=0 for 5 cycles -> pld/txnid stable, all ch_req_rdy=0; rdy=1 -> the next request is loaded in the same cycle.
- Bad response and reset: txnid 0x25 while cnt[2]=0 -> accepted, dropped, err_bad_rsp=1 for one cycle. Then rst=1 with REQ_REG and an RSP_REG full -> all vld=0 next cycle, seq restarts at 0, idle=1.

Source files
------------

// File: rtl/icache_upstream_arb.sv
// rtl/icache_upstream_arb.sv - N-channel round-robin request arbiter with txnid stamping, response routing and per-channel credits
module icache_upstream_arb #(
  parameter int NUM_CH    = 4,
  parameter int TXNID_W   = 6,
  parameter int DATA_W    = 256,
  parameter int REQ_W     = 64,
  parameter int MAX_OUTST = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          ch_req_vld,
  output logic [NUM_CH-1:0]          ch_req_rdy,
  input  logic [NUM_CH*REQ_W-1:0]    ch_req_pld,
  output logic                       upstream_rxreq_vld,
  input  logic                       upstream_rxreq_rdy,
  output logic [REQ_W-1:0]           upstream_rxreq_pld,
  output logic [TXNID_W-1:0]         upstream_rxreq_txnid,
  input  logic                       upstream_txdat_vld,
  output logic                       upstream_txdat_rdy,
  input  logic [DATA_W-1:0]          upstream_txdat_data,
  input  logic [TXNID_W-1:0]         upstream_txdat_txnid,
  output logic [NUM_CH-1:0]          ch_rsp_vld,
  input  logic [NUM_CH-1:0]          ch_rsp_rdy,
  output logic [NUM_CH*DATA_W-1:0]   ch_rsp_data,
  output logic [NUM_CH*(TXNID_W-$clog2(NUM_CH))-1:0] ch_rsp_seq,
  output logic                       err_bad_rsp,
  output logic                       idle
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int SEQ_W = TXNID_W - CH_W;
  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  logic                           req_vld_q, req_vld_d;
  logic [REQ_W-1:0]               req_pld_q, req_pld_d;
  logic [TXNID_W-1:0]             req_txnid_q, req_txnid_d;
  logic [CH_W-1:0]                rr_q, rr_d;
  logic [NUM_CH-1:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_CH-1:0][SEQ_W-1:0]   seq_q, seq_d;
  logic [NUM_CH-1:0]              rsp_vld_q, rsp_vld_d;
  logic [NUM_CH*DATA_W-1:0]       rsp_data_q, rsp_data_d;
  logic [NUM_CH*SEQ_W-1:0]        rsp_seq_q, rsp_seq_d;
  logic                           err_q;
  logic                           idle_q;

  logic                           req_free;
  logic [NUM_CH-1:0]              elig;
  logic [NUM_CH-1:0]              grant;
  logic [CH_W-1:0]                win;
  logic [CH_W-1:0]                cand;
  logic                           found;
  logic [CH_W-1:0]                rsp_ch;
  logic                           rsp_ok;
  logic                           rsp_hs;
  logic                           rsp_bad;
  logic [NUM_CH-1:0]              rsp_drain;

  // Channel eligibility: requesting and below its outstanding-credit limit
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      elig[i] = ch_req_vld[i] && (cnt_q[i] < CNT_W'(MAX_OUTST));
    end
  end

  // Round-robin search starting at the pointer; the request register frees up in the same cycle it drains
  always_comb begin
    req_free = !req_vld_q || upstream_rxreq_rdy;
    grant    = '0;
    win      = '0;
    cand     = '0;
    found    = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = rr_q + CH_W'(k);
      if (!found && req_free && elig[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        win         = cand;
      end
    end
  end

  // Response decode; the channel field is CH_W wide so it always names a real channel,
  // leaving a zero outstanding count as the only way a response can be bad
  always_comb begin
    rsp_ch             = upstream_txdat_txnid[TXNID_W-1:SEQ_W];
    rsp_ok             = (cnt_q[rsp_ch] != '0);
    rsp_drain          = rsp_vld_q & ch_rsp_rdy;
    upstream_txdat_rdy = rsp_ok ? (!rsp_vld_q[rsp_ch] || ch_rsp_rdy[rsp_ch]) : 1'b1;
    rsp_hs             = upstream_txdat_vld && upstream_txdat_rdy && rsp_ok;
    rsp_bad            = upstream_txdat_vld && !rsp_ok;
  end

  // Next-state for request register, pointer, per-channel counters and response registers
  always_comb begin
    req_vld_d   = req_vld_q;
    req_pld_d   = req_pld_q;
    req_txnid_d = req_txnid_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    seq_d       = seq_q;
    rsp_vld_d   = rsp_vld_q;
    rsp_data_d  = rsp_data_q;
    rsp_seq_d   = rsp_seq_q;

    if (req_vld_q && upstream_rxreq_rdy) begin
      req_vld_d = 1'b0;
    end
    if (found) begin
      req_vld_d   = 1'b1;
      req_pld_d   = ch_req_pld[win*REQ_W +: REQ_W];
      req_txnid_d = {win, seq_q[win]};
      rr_d        = win + CH_W'(1);
    end

    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) begin
        seq_d[i] = seq_q[i] + SEQ_W'(1);
      end
      // Credit returns only when the channel consumes the response
      case ({grant[i], rsp_drain[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CNT_W'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - CNT_W'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
      if (rsp_drain[i]) begin
        rsp_vld_d[i] = 1'b0;
      end
      if (rsp_hs && (rsp_ch == CH_W'(i))) begin
        rsp_vld_d[i]                  = 1'b1;
        rsp_data_d[i*DATA_W +: DATA_W] = upstream_txdat_data;
        rsp_seq_d[i*SEQ_W +: SEQ_W]    = upstream_txdat_txnid[SEQ_W-1:0];
      end
    end
  end

  // State registers with synchronous reset; idle is derived from the present state only
  always_ff @(posedge clk) begin
    if (rst) begin
      req_vld_q   <= 1'b0;
      req_pld_q   <= '0;
      req_txnid_q <= '0;
      rr_q        <= '0;
      cnt_q       <= '0;
      seq_q       <= '0;
      rsp_vld_q   <= '0;
      rsp_data_q  <= '0;
      rsp_seq_q   <= '0;
      err_q       <= 1'b0;
      idle_q      <= 1'b1;
    end else begin
      req_vld_q   <= req_vld_d;
      req_pld_q   <= req_pld_d;
      req_txnid_q <= req_txnid_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      seq_q       <= seq_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_data_q  <= rsp_data_d;
      rsp_seq_q   <= rsp_seq_d;
      err_q       <= rsp_bad;
      idle_q      <= !req_vld_q && (rsp_vld_q == '0) && (cnt_q == '0);
    end
  end

  assign ch_req_rdy           = grant;
  assign upstream_rxreq_vld   = req_vld_q;
  assign upstream_rxreq_pld   = req_pld_q;
  assign upstream_rxreq_txnid = req_txnid_q;
  assign ch_rsp_vld           = rsp_vld_q;
  assign ch_rsp_data          = rsp_data_q;
  assign ch_rsp_seq           = rsp_seq_q;
  assign err_bad_rsp          = err_q;
  assign idle                 = idle_q;

endmodule

// File: tb/tb_icache_upstream_arb.sv
// tb/tb_icache_upstream_arb.sv - scoreboard bench for icache_upstream_arb
module tb_icache_upstream_arb;

  logic           clk;
  logic           rst;
  logic [3:0]     ch_req_vld;
  logic [3:0]     ch_req_rdy;
  logic [255:0]   ch_req_pld;
  logic           upstream_rxreq_vld;
  logic           upstream_rxreq_rdy;
  logic [63:0]    upstream_rxreq_pld;
  logic [5:0]     upstream_rxreq_txnid;
  logic           upstream_txdat_vld;
  logic           upstream_txdat_rdy;
  logic [255:0]   upstream_txdat_data;
  logic [5:0]     upstream_txdat_txnid;
  logic [3:0]     ch_rsp_vld;
  logic [3:0]     ch_rsp_rdy;
  logic [1023:0]  ch_rsp_data;
  logic [15:0]    ch_rsp_seq;
  logic           err_bad_rsp;
  logic           idle;

  icache_upstream_arb dut (
    .clk                  (clk),
    .rst                  (rst),
    .ch_req_vld           (ch_req_vld),
    .ch_req_rdy           (ch_req_rdy),
    .ch_req_pld           (ch_req_pld),
    .upstream_rxreq_vld   (upstream_rxreq_vld),
    .upstream_rxreq_rdy   (upstream_rxreq_rdy),
    .upstream_rxreq_pld   (upstream_rxreq_pld),
    .upstream_rxreq_txnid (upstream_rxreq_txnid),
    .upstream_txdat_vld   (upstream_txdat_vld),
    .upstream_txdat_rdy   (upstream_txdat_rdy),
    .upstream_txdat_data  (upstream_txdat_data),
    .upstream_txdat_txnid (upstream_txdat_txnid),
    .ch_rsp_vld           (ch_rsp_vld),
    .ch_rsp_rdy           (ch_rsp_rdy),
    .ch_rsp_data          (ch_rsp_data),
    .ch_rsp_seq           (ch_rsp_seq),
    .err_bad_rsp          (err_bad_rsp),
    .idle                 (idle)
  );

  typedef struct packed {
    logic [63:0] pld;
    logic [5:0]  txnid;
  } up_t;

  typedef struct packed {
    logic [1:0]   ch;
    logic [3:0]   seq;
    logic [255:0] data;
  } rsp_t;

  up_t         up_q[$];
  rsp_t        rsp_q[$];
  logic [63:0] pld_v [4];
  logic [3:0]  model_seq [4];
  int          pld_ctr;
  int          checks;
  int          errors;
  logic [63:0] held_pld;

  assign ch_req_pld = {pld_v[3], pld_v[2], pld_v[1], pld_v[0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] mkdata(input logic [5:0] t);
    mkdata = {8{26'h15A5A5A, t}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request cycle: drive valids, compare the grant with the hand-computed vector, record expected upstream requests
  task automatic issue_cycle(input logic [3:0] vld, input logic [3:0] exp_gnt);
    ch_req_vld = vld;
    @(negedge clk);
    chk("ch_req_rdy", ch_req_rdy, exp_gnt);
    for (int i = 0; i < 4; i++) begin
      if (exp_gnt[i]) begin
        up_q.push_back({pld_v[i], 2'(i), model_seq[i]});
        model_seq[i] = model_seq[i] + 4'd1;
      end
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      if (exp_gnt[i]) begin
        pld_v[i] = {32'hC0DE0000 + 32'(i), 32'(pld_ctr)};
        pld_ctr++;
      end
    end
  endtask

  // Present one upstream response and wait (bounded) for acceptance; the expected channel delivery is queued
  task automatic send_rsp(input logic [5:0] t);
    bit done;
    done = 1'b0;
    upstream_txdat_vld   = 1'b1;
    upstream_txdat_txnid = t;
    upstream_txdat_data  = mkdata(t);
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      if (upstream_txdat_rdy) begin
        rsp_q.push_back({t[5:4], t[3:0], mkdata(t)});
        done = 1'b1;
      end
      tick();
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_rsp_timeout txnid=%0h act=rdy_low exp=rdy_high", t);
    end
    upstream_txdat_vld   = 1'b0;
    upstream_txdat_txnid = '0;
    upstream_txdat_data  = '0;
  endtask

  // Upstream request monitor
  always @(negedge clk) begin
    if (!rst && upstream_rxreq_vld && upstream_rxreq_rdy) begin
      if (up_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL up_unexpected act=%0h exp=none", upstream_rxreq_txnid);
      end else begin
        chk("up_txnid", upstream_rxreq_txnid, up_q[0].txnid);
        chk("up_pld", upstream_rxreq_pld, up_q[0].pld);
        void'(up_q.pop_front());
      end
    end
  end

  // Per-channel response monitor: first queued entry for the channel must match
  always @(negedge clk) begin
    if (!rst) begin
      for (int c = 0; c < 4; c++) begin
        if (ch_rsp_vld[c] && ch_rsp_rdy[c]) begin
          int idx;
          idx = -1;
          for (int k = 0; k < rsp_q.size(); k++) begin
            if (idx < 0 && rsp_q[k].ch == 2'(c)) idx = k;
          end
          if (idx < 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected ch=%0d act_seq=%0h exp=none", c, ch_rsp_seq[c*4 +: 4]);
          end else begin
            chk("rsp_seq", ch_rsp_seq[c*4 +: 4], rsp_q[idx].seq);
            chk("rsp_data", ch_rsp_data[c*256 +: 256], rsp_q[idx].data);
            rsp_q.delete(idx);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    checks  = 0;
    errors  = 0;
    pld_ctr = 0;
    for (int i = 0; i < 4; i++) begin
      pld_v[i]     = {32'hC0DE0000 + 32'(i), 32'hFFFF0000 + 32'(i)};
      model_seq[i] = 4'd0;
    end
    rst                  = 1'b1;
    ch_req_vld           = '0;
    upstream_rxreq_rdy   = 1'b1;
    upstream_txdat_vld   = 1'b0;
    upstream_txdat_data  = '0;
    upstream_txdat_txnid = '0;
    ch_rsp_rdy           = 4'b1111;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_rxreq_vld", upstream_rxreq_vld, 1'b0);
    chk("rst_rsp_vld", ch_rsp_vld, 4'b0000);
    chk("rst_err", err_bad_rsp, 1'b0);
    chk("rst_idle", idle, 1'b1);

    // Single channel: txnids 0x00..0x02, one-cycle latency
    issue_cycle(4'b0001, 4'b0001);
    chk("lat_vld", upstream_rxreq_vld, 1'b1);
    chk("lat_txnid", upstream_rxreq_txnid, 6'h00);
    issue_cycle(4'b0001, 4'b0001);
    issue_cycle(4'b0001, 4'b0001);
    issue_cycle(4'b0000, 4'b0000);
    send_rsp(6'h00);
    send_rsp(6'h01);
    send_rsp(6'h02);
    repeat (3) tick();
    chk("t1_idle", idle, 1'b1);

    // Contention: pointer sits at 1 after the ch0 burst
    issue_cycle(4'b1111, 4'b0010);
    issue_cycle(4'b1111, 4'b0100);
    issue_cycle(4'b1111, 4'b1000);
    issue_cycle(4'b1111, 4'b0001);
    issue_cycle(4'b1111, 4'b0010);
    issue_cycle(4'b1111, 4'b0100);
    issue_cycle(4'b1111, 4'b1000);
    issue_cycle(4'b1111, 4'b0001);
    issue_cycle(4'b0000, 4'b0000);

    // Out of order with channel 3 backpressured
    ch_rsp_rdy = 4'b0111;
    send_rsp(6'h31);
    send_rsp(6'h10);
    chk("ooo_buf_vld", ch_rsp_vld[3], 1'b1);
    upstream_txdat_vld   = 1'b1;
    upstream_txdat_txnid = 6'h30;
    upstream_txdat_data  = mkdata(6'h30);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("ooo_txdat_bp", upstream_txdat_rdy, 1'b0);
      tick();
    end
    ch_rsp_rdy = 4'b1111;
    @(negedge clk);
    chk("ooo_txdat_rel", upstream_txdat_rdy, 1'b1);
    if (upstream_txdat_rdy) rsp_q.push_back({2'd3, 4'd0, mkdata(6'h30)});
    tick();
    upstream_txdat_vld = 1'b0;
    send_rsp(6'h11);
    send_rsp(6'h20);
    send_rsp(6'h21);
    send_rsp(6'h03);
    send_rsp(6'h04);
    repeat (3) tick();
    chk("t2_idle", idle, 1'b1);

    // Credit stall on channel 2
    issue_cycle(4'b0100, 4'b0100);
    issue_cycle(4'b0100, 4'b0100);
    issue_cycle(4'b0100, 4'b0100);
    issue_cycle(4'b0100, 4'b0100);
    issue_cycle(4'b0110, 4'b0010);
    issue_cycle(4'b0110, 4'b0010);
    issue_cycle(4'b0100, 4'b0000);
    send_rsp(6'h22);
    issue_cycle(4'b0100, 4'b0000);
    issue_cycle(4'b0100, 4'b0100);
    issue_cycle(4'b0000, 4'b0000);
    send_rsp(6'h23);
    send_rsp(6'h24);
    send_rsp(6'h25);
    send_rsp(6'h26);
    send_rsp(6'h12);
    send_rsp(6'h13);

    // Upstream backpressure
    upstream_rxreq_rdy = 1'b0;
    held_pld = pld_v[0];
    issue_cycle(4'b0001, 4'b0001);
    for (int n = 0; n < 5; n++) begin
      issue_cycle(4'b1001, 4'b0000);
      chk("bp_vld", upstream_rxreq_vld, 1'b1);
      chk("bp_txnid", upstream_rxreq_txnid, 6'h05);
      chk("bp_pld", upstream_rxreq_pld, held_pld);
    end
    upstream_rxreq_rdy = 1'b1;
    issue_cycle(4'b1000, 4'b1000);
    chk("bp_next_txnid", upstream_rxreq_txnid, 6'h32);
    issue_cycle(4'b0000, 4'b0000);
    send_rsp(6'h05);
    send_rsp(6'h32);
    repeat (3) tick();
    chk("t4_idle", idle, 1'b1);

    // Bad response: channel 2 has nothing outstanding
    upstream_txdat_vld   = 1'b1;
    upstream_txdat_txnid = 6'h25;
    upstream_txdat_data  = mkdata(6'h25);
    @(negedge clk);
    chk("bad_rdy", upstream_txdat_rdy, 1'b1);
    tick();
    upstream_txdat_vld = 1'b0;
    chk("bad_err_pulse", err_bad_rsp, 1'b1);
    chk("bad_no_rsp", ch_rsp_vld, 4'b0000);
    tick();
    chk("bad_err_clear", err_bad_rsp, 1'b0);
    chk("bad_idle", idle, 1'b1);

    // Reset with a held request and a buffered response
    upstream_rxreq_rdy = 1'b0;
    ch_rsp_rdy         = 4'b1101;
    issue_cycle(4'b0010, 4'b0010);
    ch_req_vld = 4'b0000;
    send_rsp(6'h14);
    chk("pre_rst_req", upstream_rxreq_vld, 1'b1);
    chk("pre_rst_rsp", ch_rsp_vld[1], 1'b1);
    rst = 1'b1;
    up_q.delete();
    rsp_q.delete();
    for (int i = 0; i < 4; i++) model_seq[i] = 4'd0;
    tick();
    chk("mid_rst_req", upstream_rxreq_vld, 1'b0);
    chk("mid_rst_rsp", ch_rsp_vld, 4'b0000);
    chk("mid_rst_idle", idle, 1'b1);
    rst                = 1'b0;
    upstream_rxreq_rdy = 1'b1;
    ch_rsp_rdy         = 4'b1111;
    issue_cycle(4'b0010, 4'b0010);
    chk("post_rst_txnid", upstream_rxreq_txnid, 6'h10);
    issue_cycle(4'b0000, 4'b0000);
    send_rsp(6'h10);
    repeat (4) tick();
    chk("end_idle", idle, 1'b1);
    chk("end_up_q", 32'(up_q.size()), 32'd0);
    chk("end_rsp_q", 32'(rsp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
